// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and typedefs for the multi-port register file
package rf_pkg;
  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;
  localparam int RF_AW   = $clog2(RF_NREG);

  typedef logic [RF_AW-1:0]   rf_addr_t;
  typedef logic [RF_XLEN-1:0] rf_data_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with reserve/write-back priority
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG   = RF_NREG,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic [NREG-1:0]      busy_q,
  output logic [NREG-1:0]      busy_d
);

  // Reserve is applied after the write-back clears so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) busy_d[wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with registered bypassed reads and scoreboard
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREG   = RF_NREG,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD-1:0]      rd_req,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_valid,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  output logic [NREG-1:0]        busy_vec
);

  logic [XLEN-1:0]        regs_q [NREG];
  logic [XLEN-1:0]        regs_d [NREG];
  logic [NUM_RD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]      rd_valid_q, rd_valid_d;
  logic [NUM_RD-1:0]      rd_busy_q, rd_busy_d;
  logic [NREG-1:0]        busy_q, busy_d;

  rf_scoreboard #(
    .NREG   (NREG),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_q   (busy_q),
    .busy_d   (busy_d)
  );

  // Ascending port order makes the highest-index writer win on address clashes.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
    end
    regs_d[0] = '0;
  end

  // Reads look at next-state storage and scoreboard, giving same-cycle bypass.
  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    rd_busy_d  = rd_busy_q;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_req[i]) begin
        rd_data_d[i*XLEN +: XLEN] = regs_d[rd_addr[i*AW +: AW]];
        rd_busy_d[i]              = busy_d[rd_addr[i*AW +: AW]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NREG; n++) regs_q[n] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      rd_busy_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_busy_q  <= rd_busy_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_busy  = rd_busy_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed table-driven bench for regfile_mp with two write ports
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_req;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [31:0] busy_vec;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN   (32),
    .NREG   (32),
    .NUM_RD (2),
    .NUM_WR (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec)
  );

  typedef struct packed {
    logic [1:0]  wr_en;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [1:0]  rd_req;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [1:0]  e_valid;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [1:0]  e_busy;
    logic [31:0] e_bv;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_req   = '0;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] ev, input logic [31:0] d0,
                               input logic [31:0] d1, input logic [1:0] eb, input logic [31:0] bv);
    chk({tag, " valid"}, {30'd0, rd_valid}, {30'd0, ev});
    chk({tag, " d0"}, rd_data[31:0], d0);
    chk({tag, " d1"}, rd_data[63:32], d1);
    chk({tag, " busy"}, {30'd0, rd_busy}, {30'd0, eb});
    chk({tag, " busy_vec"}, busy_vec, bv);
  endtask

  initial begin
    //          wr_en  wa0   wd0            wa1   wd1         rsv   ra    req    ra0   ra1    ev     d0             d1             eb     bv
    vecs[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,      1'b0, 5'd0, 2'b00, 5'd0, 5'd0,  2'b00, 32'h0,        32'h0,         2'b00, 32'h0};
    vecs[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd0, 2'b11, 5'd5, 5'd5,  2'b11, 32'hDEADBEEF, 32'hDEADBEEF,  2'b00, 32'h0};
    vecs[2]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd0, 2'b00, 5'd0, 5'd0,  2'b00, 32'hDEADBEEF, 32'hDEADBEEF,  2'b00, 32'h0};
    vecs[3]  = '{2'b01, 5'd7, 32'h1234,     5'd0, 32'h0,      1'b0, 5'd0, 2'b11, 5'd7, 5'd5,  2'b11, 32'h1234,     32'hDEADBEEF,  2'b00, 32'h0};
    vecs[4]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,      1'b1, 5'd0, 2'b11, 5'd0, 5'd7,  2'b11, 32'h0,        32'h1234,      2'b00, 32'h0};
    vecs[5]  = '{2'b11, 5'd3, 32'hA,        5'd3, 32'hB,      1'b0, 5'd0, 2'b01, 5'd3, 5'd0,  2'b01, 32'hB,        32'h1234,      2'b00, 32'h0};
    vecs[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd0, 2'b10, 5'd0, 5'd3,  2'b10, 32'hB,        32'hB,         2'b00, 32'h0};
    vecs[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b1, 5'd9, 2'b01, 5'd9, 5'd0,  2'b01, 32'h0,        32'hB,         2'b01, 32'h200};
    vecs[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd0, 2'b10, 5'd0, 5'd9,  2'b10, 32'h0,        32'h0,         2'b11, 32'h200};
    vecs[9]  = '{2'b10, 5'd0, 32'h0,        5'd9, 32'h99,     1'b0, 5'd0, 2'b01, 5'd9, 5'd0,  2'b01, 32'h99,       32'h0,         2'b10, 32'h0};
    vecs[10] = '{2'b01, 5'd9, 32'h55,       5'd0, 32'h0,      1'b1, 5'd9, 2'b01, 5'd9, 5'd0,  2'b01, 32'h55,       32'h0,         2'b11, 32'h200};
    vecs[11] = '{2'b01, 5'd9, 32'h66,       5'd0, 32'h0,      1'b1, 5'd12, 2'b00, 5'd0, 5'd0, 2'b00, 32'h55,       32'h0,         2'b11, 32'h1000};
    vecs[12] = '{2'b10, 5'd0, 32'h0,        5'd12, 32'h77,    1'b1, 5'd9, 2'b11, 5'd12, 5'd9, 2'b11, 32'h77,       32'h66,        2'b10, 32'h200};
    vecs[13] = '{2'b11, 5'd1, 32'h11,       5'd2, 32'h22,     1'b0, 5'd0, 2'b11, 5'd1, 5'd2,  2'b11, 32'h11,       32'h22,        2'b00, 32'h200};

    // Reset with conflicting activity on the inputs: reset must dominate.
    idle_inputs();
    rst      = 1'b1;
    wr_en    = 2'b11;
    wr_addr  = {5'd4, 5'd4};
    wr_data  = {32'h5, 32'h6};
    rsv_en   = 1'b1;
    rsv_addr = 5'd4;
    rd_req   = 2'b11;
    rd_addr  = {5'd4, 5'd4};
    tick();
    tick();
    check_outputs("reset", 2'b00, 32'h0, 32'h0, 2'b00, 32'h0);
    idle_inputs();
    rst = 1'b0;

    for (int r = 0; r < 32; r += 2) begin
      rd_req  = 2'b11;
      rd_addr = {5'(r + 1), 5'(r)};
      tick();
      check_outputs($sformatf("rst_read x%0d", r), 2'b11, 32'h0, 32'h0, 2'b00, 32'h0);
    end
    idle_inputs();
    tick();

    for (int v = 0; v < NV; v++) begin
      wr_en    = vecs[v].wr_en;
      wr_addr  = {vecs[v].wa1, vecs[v].wa0};
      wr_data  = {vecs[v].wd1, vecs[v].wd0};
      rsv_en   = vecs[v].rsv_en;
      rsv_addr = vecs[v].rsv_addr;
      rd_req   = vecs[v].rd_req;
      rd_addr  = {vecs[v].ra1, vecs[v].ra0};
      tick();
      check_outputs($sformatf("vec%0d", v), vecs[v].e_valid, vecs[v].e_d0, vecs[v].e_d1,
                    vecs[v].e_busy, vecs[v].e_bv);
    end

    // Back-to-back requests: a result every cycle.
    idle_inputs();
    rd_req  = 2'b01;
    rd_addr = {5'd0, 5'd5};
    tick();
    chk("b2b first", rd_data[31:0], 32'hDEADBEEF);
    rd_addr = {5'd0, 5'd7};
    tick();
    chk("b2b second valid", {31'd0, rd_valid[0]}, 32'd1);
    chk("b2b second data", rd_data[31:0], 32'h1234);

    // Reset while reads are in flight drops them and clears the scoreboard.
    rd_req  = 2'b11;
    rd_addr = {5'd1, 5'd9};
    rst     = 1'b1;
    tick();
    check_outputs("rst_mid", 2'b00, 32'h0, 32'h0, 2'b00, 32'h0);
    rst = 1'b0;
    rd_addr = {5'd7, 5'd5};
    tick();
    check_outputs("post_rst", 2'b11, 32'h0, 32'h0, 2'b00, 32'h0);
    idle_inputs();
    tick();
    chk("post_rst idle valid", {30'd0, rd_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
